// File: rtl/byte_serial_mem_master_if.sv
// Byte-wide memory port shared by the data-memory sub-arrays.
// The master drives address, write strobe and write data; the array returns read data.
interface memory_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic [AW-1:0] addr;
  logic          wr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output addr, output wr, output wdata, input rdata);
  modport slave  (input addr, input wr, input wdata, output rdata);
endinterface

// File: rtl/byte_serial_mem_master.sv
// Serialises one CPU load/store (byte/half/word) into little-endian byte accesses
// on a memory_if slave, then assembles and extends the load result.
module byte_serial_mem_master #(
  parameter int AW   = 9,
  parameter int DW   = 8,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  memory_if.master        mem_if
);

  if (DW != 8 || XLEN != 32) begin : g_param_check
    $error("byte_serial_mem_master: DW must be 8 and XLEN must be 32");
  end

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_SAMPLE, WR, RESP} state_t;

  state_t          state;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [AW-1:0]   base_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] asm_q;
  logic [1:0]      cnt;

  logic [1:0]      cnt_nx;
  logic            last_byte;
  logic            illegal;
  logic [XLEN-1:0] asm_nx;

  // Sign or zero fill above the bytes actually read; words pass through.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] a,
                                             input logic [1:0] sz,
                                             input logic uns);
    case (sz)
      2'b00:   extend = {{(XLEN-8){~uns & a[7]}}, a[7:0]};
      2'b01:   extend = {{(XLEN-16){~uns & a[15]}}, a[15:0]};
      default: extend = a;
    endcase
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    asm_nx               = asm_q;
    asm_nx[8*cnt +: 8]   = mem_if.rdata;
    cnt_nx               = cnt + 2'd1;
    last_byte            = (cnt == {size_q[1], size_q[1] | size_q[0]});
    illegal              = (req_size == 2'b11)
                         || (req_size == 2'b01 && req_addr[0])
                         || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      mem_if.addr  <= '0;
      mem_if.wr    <= 1'b0;
      mem_if.wdata <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            base_q    <= req_addr;
            wdata_q   <= req_wdata;
            asm_q     <= '0;
            cnt       <= '0;
            req_ready <= 1'b0;
            if (illegal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_wr) begin
              state        <= WR;
              mem_if.addr  <= req_addr;
              mem_if.wdata <= req_wdata[7:0];
              mem_if.wr    <= 1'b1;
            end else begin
              state       <= RD_ADDR;
              mem_if.addr <= req_addr;
            end
          end
        end
        RD_ADDR: state <= RD_SAMPLE;
        RD_SAMPLE: begin
          asm_q <= asm_nx;
          if (last_byte) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= extend(asm_nx, size_q, uns_q);
          end else begin
            state       <= RD_ADDR;
            cnt         <= cnt_nx;
            mem_if.addr <= base_q + AW'(cnt_nx);
          end
        end
        WR: begin
          if (last_byte) begin
            state     <= RESP;
            mem_if.wr <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            cnt          <= cnt_nx;
            mem_if.addr  <= base_q + AW'(cnt_nx);
            mem_if.wdata <= wdata_q[8*cnt_nx +: 8];
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          mem_if.wr <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_mem_master.sv
// Directed bench for byte_serial_mem_master against a synchronous-read byte SRAM model.
module tb_byte_serial_mem_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  memory_if #(.AW(9), .DW(8)) mif ();

  byte_serial_mem_master #(.AW(9), .DW(8), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_if       (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Memory model: write on the edge, registered read (synchronous SRAM build).
  logic [7:0] mem [512];
  logic       mem_loaded = 1'b0;
  logic [8:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h020:   init_byte = 8'h80;
      'h021:   init_byte = 8'h7F;
      'h040:   init_byte = 8'h01;
      'h041:   init_byte = 8'h02;
      'h042:   init_byte = 8'h03;
      'h043:   init_byte = 8'h04;
      default: init_byte = 8'(i) ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_byte(i);
      mem_loaded <= 1'b1;
    end else if (mif.wr) begin
      mem[mif.addr] <= mif.wdata;
      wr_addr_q.push_back(mif.addr);
      wr_data_q.push_back(mif.wdata);
    end
    mif.rdata <= mem[mif.addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic run_req(input vec_t v, output logic [31:0] rdata, output logic err,
                         output int lat, output logic [8:0] addr_before);
    @(negedge clk);
    check({v.name, "_ready"}, 32'(req_ready), 32'd1);
    wr_addr_q.delete();
    wr_data_q.delete();
    addr_before  = mif.addr;
    req_valid    = 1'b1;
    req_wr       = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_addr     = 9'h1AB;
    req_wdata    = 32'h0BAD_0BAD;
    lat   = -1;
    rdata = 32'hFFFF_FFFF;
    err   = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat   = k;
        rdata = rsp_rdata;
        err   = rsp_err;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [8:0]  addr_before;
    int          n;
    int          exp_n;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 5, "st_word"};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0, 9, "ld_word"};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 9'h020, 32'h0,        32'hFFFFFF80, 1'b0, 3, "ld_byte_s"};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 9'h020, 32'h0,        32'h00000080, 1'b0, 3, "ld_byte_u"};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 9'h020, 32'h0,        32'h00007F80, 1'b0, 5, "ld_half_s"};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 9'h003, 32'h0,        32'h00000000, 1'b1, 1, "err_half"};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 9'h006, 32'h0,        32'h00000000, 1'b1, 1, "err_word"};
    vecs[7]  = '{1'b1, 2'b11, 1'b0, 9'h008, 32'h12345678, 32'h00000000, 1'b1, 1, "err_size"};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 9'h1FC, 32'h11223344, 32'h00000000, 1'b0, 5, "st_top"};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 9'h1FF, 32'h0,        32'h00000011, 1'b0, 3, "ld_top"};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 9'h030, 32'h12349ABC, 32'h00000000, 1'b0, 3, "st_half"};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 9'h030, 32'h0,        32'hFFFF9ABC, 1'b0, 5, "ld_half_s2"};
    vecs[12] = '{1'b0, 2'b01, 1'b1, 9'h030, 32'h0,        32'h00009ABC, 1'b0, 5, "ld_half_u"};

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_wr       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_addr", 32'(mif.addr), 32'd0);
    check("rst_wr", 32'(mif.wr), 32'd0);
    check("rst_wdata", 32'(mif.wdata), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[vi]) begin
      run_req(vecs[vi], rdata, err, lat, addr_before);
      check({vecs[vi].name, "_lat"}, 32'(lat), 32'(vecs[vi].exp_lat));
      check({vecs[vi].name, "_rdata"}, rdata, vecs[vi].exp_rdata);
      check({vecs[vi].name, "_err"}, 32'(err), 32'(vecs[vi].exp_err));
      n     = (vecs[vi].size == 2'b00) ? 1 : (vecs[vi].size == 2'b01) ? 2 : 4;
      exp_n = (vecs[vi].wr && !vecs[vi].exp_err) ? n : 0;
      check({vecs[vi].name, "_nwr"}, 32'(wr_addr_q.size()), 32'(exp_n));
      for (int j = 0; j < exp_n && j < wr_addr_q.size(); j++) begin
        check($sformatf("%s_waddr%0d", vecs[vi].name, j), 32'(wr_addr_q[j]),
              32'(vecs[vi].addr + 9'(j)));
        check($sformatf("%s_wdata%0d", vecs[vi].name, j), 32'(wr_data_q[j]),
              32'(vecs[vi].wdata[8*j +: 8]));
      end
      if (vecs[vi].exp_err)
        check({vecs[vi].name, "_addr_hold"}, 32'(mif.addr), 32'(addr_before));
      @(negedge clk);
      check({vecs[vi].name, "_pulse_end"}, 32'(rsp_valid), 32'd0);
      check({vecs[vi].name, "_rdata_held"}, rsp_rdata, vecs[vi].exp_rdata);
    end

    // Back-to-back byte stores with req_valid held high throughout.
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 9'h050;
    req_wdata = 32'h000000A5;
    @(posedge clk);
    #1;
    req_addr  = 9'h051;
    req_wdata = 32'h0000005A;
    @(negedge clk);
    check("b2b_c1_ready", 32'(req_ready), 32'd0);
    check("b2b_c1_wr", 32'(mif.wr), 32'd1);
    @(negedge clk);
    check("b2b_c2_ready", 32'(req_ready), 32'd0);
    check("b2b_c2_rsp", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("b2b_c3_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_c4_ready", 32'(req_ready), 32'd0);
    check("b2b_c4_addr", 32'(mif.addr), 32'h051);
    @(negedge clk);
    check("b2b_c5_rsp", 32'(rsp_valid), 32'd1);
    repeat (2) @(negedge clk);
    check("b2b_nwr", 32'(wr_addr_q.size()), 32'd2);
    check("b2b_mem50", 32'(mem[9'h050]), 32'h0A5);
    check("b2b_mem51", 32'(mem[9'h051]), 32'h05A);

    // Reset asserted during the third WR cycle of a word store.
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 9'h040;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_wr_before", 32'(mif.wr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_wr_drop", 32'(mif.wr), 32'd0);
    check("rstmid_rsp", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rstmid_norsp%0d", k), 32'(rsp_valid), 32'd0);
    end
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_nwr", 32'(wr_addr_q.size()), 32'd2);
    check("rstmid_mem40", 32'(mem[9'h040]), 32'h00D);
    check("rstmid_mem41", 32'(mem[9'h041]), 32'h0F0);
    check("rstmid_mem42", 32'(mem[9'h042]), 32'h003);
    check("rstmid_mem43", 32'(mem[9'h043]), 32'h004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
